// File: rtl/hb_pkg.sv
// Shared types and helpers for the heartbeat PWM engine: mode encodings,
// the lub-dub brightness envelope and the phase increment constant.
package hb_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STEADY = 2'd1,
    MODE_HEART  = 2'd2,
    MODE_RIPPLE = 2'd3
  } mode_e;

  localparam int PHASE_W = 40;

  // Two-hump envelope over one beat: tall "lub" peaking at 240, then a
  // smaller "dub" peaking at 132, dark for the rest of the cycle.
  function automatic logic [7:0] hb_env(input logic [7:0] p);
    logic [7:0] e;
    e = 8'd0;
    if (p <= 8'd15)                      e = 8'(p << 4);
    else if (p <= 8'd31)                 e = 8'((8'd31 - p) << 4);
    else if (p >= 8'd48 && p <= 8'd59)   e = (p - 8'd48) * 8'd12;
    else if (p >= 8'd60 && p <= 8'd71)   e = (8'd71 - p) * 8'd12;
    return e;
  endfunction

  // Per-bpm phase increment: one bpm unit advances the 40-bit accumulator
  // by 2^40 / (60 * clk_hz), rounded to nearest.
  function automatic logic [PHASE_W-1:0] calc_k(input longint unsigned clk_hz);
    longint unsigned d;
    d = 64'd60 * clk_hz;
    return PHASE_W'(((64'd1 << PHASE_W) + (d >> 1)) / d);
  endfunction

endpackage

// File: rtl/heartbeat_pwm_engine_if.sv
// Control/status bundle between the switch/key front end and the engine.
interface heartbeat_pwm_engine_if #(
  parameter int N_LED = 8
);
  logic [1:0]       mode;
  logic             bpm_up;
  logic             bpm_dn;
  logic [N_LED-1:0] led;
  logic [7:0]       bpm;
  logic             beat;

  modport master (output mode, bpm_up, bpm_dn, input led, bpm, beat);
  modport slave  (input mode, bpm_up, bpm_dn, output led, bpm, beat);
endinterface

// File: rtl/hb_pwm_channel.sv
// One LED lane: registered duty-vs-counter compare with off/steady overrides.
module hb_pwm_channel
  import hb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] duty,
  input  logic [7:0] pwm_cnt,
  input  mode_e      mode,
  output logic       led
);

  logic led_d, led_q;

  // lit while duty exceeds the counter, so duty 0 is fully dark
  always_comb begin
    led_d = 1'b0;
    unique case (mode)
      MODE_OFF:    led_d = 1'b0;
      MODE_STEADY: led_d = 1'b1;
      default:     led_d = (duty > pwm_cnt);
    endcase
  end

  // output register, cleared on reset
  always_ff @(posedge clk) begin
    if (!rst_n) led_q <= 1'b0;
    else        led_q <= led_d;
  end

  assign led = led_q;

endmodule

// File: rtl/heartbeat_pwm_engine.sv
// N-channel heartbeat/breathing LED engine: bpm register with saturating
// step control, 40-bit phase accumulator, shared PWM counter, beat strobe.
module heartbeat_pwm_engine
  import hb_pkg::*;
#(
  parameter int CLK_HZ       = 12_000_000,
  parameter int N_LED        = 8,
  parameter int BPM_MIN      = 40,
  parameter int BPM_MAX      = 180,
  parameter int BPM_DEFAULT  = 72,
  parameter int BPM_STEP     = 4,
  parameter int PHASE_SPREAD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  heartbeat_pwm_engine_if.slave hb
);

  localparam logic [PHASE_W-1:0] K = calc_k(longint'(CLK_HZ));

  logic [7:0]         bpm_q, bpm_d;
  logic [PHASE_W-1:0] phase_acc_q, phase_acc_d;
  logic [7:0]         pwm_cnt_q, pwm_cnt_d;
  logic               beat_q, beat_d;

  logic [PHASE_W:0]   acc_sum;
  logic [8:0]         bpm_inc, bpm_dec;
  logic [7:0]         phase;
  mode_e              mode;
  logic [N_LED-1:0]   led;

  assign mode  = mode_e'(hb.mode);
  assign phase = phase_acc_q[PHASE_W-1:PHASE_W-8];

  // next state: bpm steps are computed 9 bits wide so clamping sees any
  // overflow/underflow; the accumulator carry-out is the beat strobe
  always_comb begin
    acc_sum     = {1'b0, phase_acc_q} + {1'b0, PHASE_W'(bpm_q) * K};
    bpm_inc     = {1'b0, bpm_q} + 9'(BPM_STEP);
    bpm_dec     = {1'b0, bpm_q} - 9'(BPM_STEP);
    bpm_d       = bpm_q;
    if (hb.bpm_up && !hb.bpm_dn)
      bpm_d = (bpm_inc > 9'(BPM_MAX)) ? 8'(BPM_MAX) : bpm_inc[7:0];
    else if (hb.bpm_dn && !hb.bpm_up)
      bpm_d = (bpm_dec[8] || bpm_dec < 9'(BPM_MIN)) ? 8'(BPM_MIN) : bpm_dec[7:0];
    phase_acc_d = acc_sum[PHASE_W-1:0];
    pwm_cnt_d   = pwm_cnt_q + 8'd1;
    beat_d      = acc_sum[PHASE_W];
  end

  // state registers; a bpm change never touches the accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bpm_q       <= 8'(BPM_DEFAULT);
      phase_acc_q <= '0;
      pwm_cnt_q   <= 8'd0;
      beat_q      <= 1'b0;
    end else begin
      bpm_q       <= bpm_d;
      phase_acc_q <= phase_acc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      beat_q      <= beat_d;
    end
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_lane
    logic [7:0] lane_phase, duty;
    // ripple mode delays each lane by i*PHASE_SPREAD phase units
    assign lane_phase = (mode == MODE_RIPPLE) ? phase - 8'(i * PHASE_SPREAD) : phase;
    assign duty       = hb_env(lane_phase);
    hb_pwm_channel u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .duty    (duty),
      .pwm_cnt (pwm_cnt_q),
      .mode    (mode),
      .led     (led[i])
    );
  end

  assign hb.led  = led;
  assign hb.bpm  = bpm_q;
  assign hb.beat = beat_q;

endmodule
